// File: rtl/tdl_pkg.sv
// Shared defaults and readout state type for the parametrised tap delay line.
package tdl_pkg;

    localparam int unsigned TDL_DATA_W = 14;
    localparam int unsigned TDL_TAPS   = 17;

    typedef enum logic {
        RD_IDLE,
        RD_ACTIVE
    } rd_state_t;

    // Width able to hold 0..taps inclusive (fill count and tap index).
    function automatic int unsigned tdl_cnt_w(input int unsigned taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/tap_read_seq.sv
// Serial tap readout sequencer: walks rd_idx 0..TAPS-1 once per rd_start, one tap per cycle.
module tap_read_seq
    import tdl_pkg::*;
#(
    parameter int unsigned TAPS  = TDL_TAPS,
    parameter int unsigned CNT_W = tdl_cnt_w(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_start,
    output logic             rd_busy,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_idx,
    output logic             rd_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    rd_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RD_IDLE;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            rd_last  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (rd_start) begin
                        state    <= RD_ACTIVE;
                        rd_busy  <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_idx   <= '0;
                        rd_last  <= 1'b0;
                    end
                end
                RD_ACTIVE: begin
                    // rd_start is deliberately not looked at here, including the last beat.
                    if (rd_idx == LAST_IDX) begin
                        state    <= RD_IDLE;
                        rd_busy  <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_idx   <= '0;
                        rd_last  <= 1'b0;
                    end else begin
                        rd_idx  <= rd_idx + ONE;
                        rd_last <= ((rd_idx + ONE) == LAST_IDX);
                    end
                end
                default: begin
                    state    <= RD_IDLE;
                    rd_busy  <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_idx   <= '0;
                    rd_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tap_delay_line_p.sv
// Parametrised sample delay line: TAPS-deep shift register with handshake, fill count,
// frame-start clearing and a serial readout port for a time-multiplexed MAC.
module tap_delay_line_p
    import tdl_pkg::*;
#(
    parameter  int unsigned DATA_W = TDL_DATA_W,
    parameter  int unsigned TAPS   = TDL_TAPS,
    localparam int unsigned CNT_W  = tdl_cnt_w(TAPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   head_flag,
    output logic [TAPS*DATA_W-1:0] taps_flat,
    output logic [CNT_W-1:0]       fill_cnt,
    output logic                   full,
    input  logic                   rd_start,
    output logic                   rd_busy,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       rd_idx,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_last
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [DATA_W-1:0] tap_q [TAPS];
    logic [CNT_W-1:0]  fill_q;
    logic              rst_any;
    logic              accept;

    assign rst_any  = rst | clear;
    assign in_ready = !rd_busy && !rst && !clear;
    assign accept   = in_valid && in_ready;

    tap_read_seq #(
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) u_read_seq (
        .clk      (clk),
        .rst      (rst_any),
        .rd_start (rd_start),
        .rd_busy  (rd_busy),
        .rd_valid (rd_valid),
        .rd_idx   (rd_idx),
        .rd_last  (rd_last)
    );

    always_ff @(posedge clk) begin
        if (rst_any) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                tap_q[k] <= '0;
            end
            fill_q <= '0;
        end else if (accept) begin
            tap_q[0] <= in_data;
            // A frame head restarts the history: older taps read as zero.
            for (int unsigned k = 1; k < TAPS; k++) begin
                tap_q[k] <= head_flag ? '0 : tap_q[k-1];
            end
            if (head_flag) begin
                fill_q <= ONE;
            end else if (fill_q != FULL_CNT) begin
                fill_q <= fill_q + ONE;
            end
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == FULL_CNT);

    always_comb begin
        taps_flat = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            taps_flat[k*DATA_W +: DATA_W] = tap_q[k];
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (rd_idx == CNT_W'(k)) begin
                    rd_data = tap_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_delay_line_p.sv
// Self-checking bench for tap_delay_line_p: directed scenarios plus randomized traffic vs a queue model.
module tb_tap_delay_line_p;

    localparam int unsigned DW = 14;
    localparam int unsigned NT = 17;
    localparam int unsigned CW = $clog2(NT + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              head_flag = 1'b0;
    logic [NT*DW-1:0]  taps_flat;
    logic [CW-1:0]     fill_cnt;
    logic              full;
    logic              rd_start = 1'b0;
    logic              rd_busy;
    logic              rd_valid;
    logic [CW-1:0]     rd_idx;
    logic [DW-1:0]     rd_data;
    logic              rd_last;

    int total = 0;
    int bad   = 0;

    tap_delay_line_p #(
        .DATA_W (DW),
        .TAPS   (NT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .head_flag (head_flag),
        .taps_flat (taps_flat),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .rd_start  (rd_start),
        .rd_busy   (rd_busy),
        .rd_valid  (rd_valid),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dut_tap(input int k);
        return taps_flat[k*DW +: DW];
    endfunction

    // Reference model: the line is a queue of the most recent samples, newest first.
    logic [DW-1:0] m_q[$];
    int            m_pos  = -1;
    bit            m_live = 1'b0;

    function automatic logic [DW-1:0] m_tap(input int k);
        return (k < m_q.size()) ? m_q[k] : '0;
    endfunction

    always @(posedge clk) begin
        if (rst || clear) begin
            m_q.delete();
            m_pos  = -1;
            m_live = 1'b1;
        end else begin
            bit busy;
            busy = (m_pos >= 0);
            if (in_valid && !busy) begin
                if (head_flag) m_q.delete();
                m_q.push_front(in_data);
                if (m_q.size() > NT) void'(m_q.pop_back());
            end
            if (busy) m_pos = (m_pos == NT - 1) ? -1 : m_pos + 1;
            else if (rd_start) m_pos = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            logic [NT*DW-1:0] exp_flat;
            logic [CW-1:0]    exp_idx;
            for (int k = 0; k < NT; k++) exp_flat[k*DW +: DW] = m_tap(k);
            exp_idx = (m_pos >= 0) ? CW'(m_pos) : '0;
            chk("m_taps_flat", 256'(taps_flat), 256'(exp_flat));
            chk("m_fill_cnt", 256'(fill_cnt), 256'(m_q.size()));
            chk("m_full", 256'(full), 256'(m_q.size() == NT));
            chk("m_in_ready", 256'(in_ready), 256'(m_pos < 0 && !rst && !clear));
            chk("m_rd_valid", 256'(rd_valid), 256'(m_pos >= 0));
            chk("m_rd_busy", 256'(rd_busy), 256'(m_pos >= 0));
            chk("m_rd_idx", 256'(rd_idx), 256'(exp_idx));
            chk("m_rd_data", 256'(rd_data), 256'((m_pos >= 0) ? m_tap(m_pos) : '0));
            chk("m_rd_last", 256'(rd_last), 256'(m_pos == NT - 1));
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic h,
                        input logic s, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        head_flag = h;
        rd_start  = s;
        rst       = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; head_flag = 1'b0;
        rd_start = 1'b0; rst = 1'b0; clear = 1'b0;
        #1;
    endtask

    initial begin
        bit reached;

        step(0, 0, 0, 0, 1, 0);
        chk("rst_fill", 256'(fill_cnt), 256'(0));
        chk("rst_full", 256'(full), 256'(0));
        chk("rst_rd_valid", 256'(rd_valid), 256'(0));
        chk("rst_in_ready_held", 256'(in_ready), 256'(0));
        idle_inputs();
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_taps", 256'(taps_flat), 256'(0));

        for (int i = 1; i <= 17; i++) begin
            step(1, DW'(i), 0, 0, 0, 0);
            chk("fill_step", 256'(fill_cnt), 256'(i));
            chk("full_step", 256'(full), 256'(i == 17));
        end
        for (int k = 0; k < 17; k++) chk("tap_after_fill", 256'(dut_tap(k)), 256'(17 - k));

        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            chk("ro_valid", 256'(rd_valid), 256'(1));
            chk("ro_idx", 256'(rd_idx), 256'(i));
            chk("ro_data", 256'(rd_data), 256'(17 - i));
            chk("ro_last", 256'(rd_last), 256'(i == 16));
            chk("ro_in_ready", 256'(in_ready), 256'(0));
            step(1, DW'(99), 0, 0, 0, 0);
        end
        chk("ro_end_valid", 256'(rd_valid), 256'(0));
        chk("ro_tap0_kept", 256'(dut_tap(0)), 256'(17));
        chk("ro_tap16_kept", 256'(dut_tap(16)), 256'(1));
        chk("ro_fill_kept", 256'(fill_cnt), 256'(17));

        step(1, DW'(18), 0, 0, 0, 0);
        step(1, DW'(19), 0, 0, 0, 0);
        step(1, DW'(20), 0, 0, 0, 0);
        chk("sat_fill", 256'(fill_cnt), 256'(17));
        chk("sat_tap0", 256'(dut_tap(0)), 256'(20));
        chk("sat_tap16", 256'(dut_tap(16)), 256'(4));
        step(1, 14'h3FFF, 0, 0, 0, 0);
        chk("max_tap0", 256'(dut_tap(0)), 256'(14'h3FFF));
        chk("max_tap1", 256'(dut_tap(1)), 256'(20));

        step(1, 14'h1FFF, 1, 0, 0, 0);
        chk("head_tap0", 256'(dut_tap(0)), 256'(14'h1FFF));
        for (int k = 1; k < 17; k++) chk("head_tapk", 256'(dut_tap(k)), 256'(0));
        chk("head_fill", 256'(fill_cnt), 256'(1));
        chk("head_full", 256'(full), 256'(0));

        step(1, DW'(5), 0, 1, 0, 0);
        chk("same_valid", 256'(rd_valid), 256'(1));
        chk("same_data", 256'(rd_data), 256'(5));
        chk("same_idx1_later", 256'(fill_cnt), 256'(2));
        for (int i = 1; i < 17; i++) step(0, 0, 0, 0, 0, 0);
        chk("restart_last", 256'(rd_last), 256'(1));
        chk("restart_idx", 256'(rd_idx), 256'(16));
        step(0, 0, 0, 1, 0, 0);
        chk("restart_ignored", 256'(rd_valid), 256'(0));
        step(0, 0, 0, 0, 0, 0);
        chk("restart_ignored2", 256'(rd_valid), 256'(0));

        step(0, 0, 0, 1, 0, 0);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (rd_valid && rd_idx == CW'(6)) reached = 1'b1;
            else step(0, 0, 0, 0, 0, 0);
        end
        chk("clr_reach_idx6", 256'(reached), 256'(1));
        step(0, 0, 0, 0, 0, 1);
        idle_inputs();
        chk("clr_rd_valid", 256'(rd_valid), 256'(0));
        chk("clr_taps", 256'(taps_flat), 256'(0));
        chk("clr_fill", 256'(fill_cnt), 256'(0));
        chk("clr_in_ready", 256'(in_ready), 256'(1));

        step(1, DW'(11), 0, 0, 0, 0);
        step(1, DW'(12), 0, 0, 0, 0);
        step(1, DW'(13), 0, 1, 0, 0);
        step(1, DW'(7), 0, 0, 1, 0);
        idle_inputs();
        chk("rst_mid_rd_valid", 256'(rd_valid), 256'(0));
        chk("rst_mid_taps", 256'(taps_flat), 256'(0));
        chk("rst_mid_fill", 256'(fill_cnt), 256'(0));
        chk("rst_mid_in_ready", 256'(in_ready), 256'(1));

        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] d;
            d = ($urandom % 10 == 0) ? 14'h3FFF : DW'($urandom);
            step(($urandom % 4) != 0, d, ($urandom % 16) == 0, ($urandom % 20) == 0,
                 ($urandom % 300) == 0, ($urandom % 200) == 0);
        end
        idle_inputs();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_delay_line_p.md
Name: tap_delay_line_p

Overview:
Parametrised sample delay line for the adaptive FIR datapath, the successor to the fixed 17x14-bit tap register bank. It holds the last TAPS input samples and exposes them in parallel as a flat vector. New over the fixed bank: a valid/ready input handshake, a fill counter, and frame-start clearing via head_flag. It also provides a sequential tap readout port that feeds a time-multiplexed MAC, one tap per cycle.

Parameters:
DATA_W, 14, sample width in bits; data is treated as raw bits, with no sign interpretation.
TAPS, 17, number of taps; legal range is 2 or more.
CNT_W, $clog2(TAPS+1), localparam; width of fill_cnt and rd_idx.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
clear  in  1  synchronous soft clear; same effect as rst.
in_valid  in  1  in_data is valid.
in_ready  out  1  line can accept a sample.
in_data  in  DATA_W  new sample.
head_flag  in  1  accepted sample is the first of a frame.
taps_flat  out  TAPS*DATA_W  tap k sits at bits [k*DATA_W +: DATA_W]; tap 0 is the newest.
fill_cnt  out  CNT_W  number of valid samples, saturating at TAPS.
full  out  1  fill_cnt == TAPS.
rd_start  in  1  request a serial readout of all taps.
rd_busy  out  1  readout in progress.
rd_valid  out  1  rd_data/rd_idx are valid.
rd_idx  out  CNT_W  tap index being presented.
rd_data  out  DATA_W  tap[rd_idx].
rd_last  out  1  rd_valid && rd_idx == TAPS-1.

Behaviour:
- Reset, applied by rst or clear in the same cycle:
  - all taps = 0; fill_cnt = 0; full = 0;
  - readout FSM = RD_IDLE; rd_valid = rd_busy = rd_last = 0; rd_idx = 0; rd_data = 0.
  - rst and clear override every other input and abort any readout.
- in_ready = !rd_busy && !rst && !clear (combinational).
- Accept = in_valid && in_ready.
- On accept without head_flag:
  - tap[0] <= in_data; tap[k] <= tap[k-1] for k = 1..TAPS-1; the old tap[TAPS-1] is discarded.
  - fill_cnt <= min(fill_cnt+1, TAPS).
  - taps_flat latency is 1 cycle.
- On accept with head_flag:
  - tap[0] <= in_data; tap[1..TAPS-1] <= 0; fill_cnt <= 1.
- head_flag without accept is ignored.
- Taps hold whenever there is no accept.
- full is registered or derived; either way it must equal (fill_cnt == TAPS) in every cycle.
- Readout FSM has two states, RD_IDLE and RD_ACTIVE:
  - RD_IDLE -> RD_ACTIVE when rd_start = 1; rd_idx <= 0.
  - In RD_ACTIVE: rd_valid = rd_busy = 1; rd_idx increments each cycle.
  - At rd_idx == TAPS-1, rd_last = 1 and the next state is RD_IDLE.
  - Exactly TAPS cycles of rd_valid are produced, with no stalls and no downstream backpressure.
- rd_data = tap[rd_idx], combinational mux from the registered index; it is 0 when rd_valid = 0.
- Taps are frozen during readout, because in_ready = 0.
- Accept and rd_start in the same cycle are both honoured. The first rd_data is the post-shift tap 0, i.e. the sample just accepted.
- rd_start while busy, including the rd_last cycle, is ignored; the requester must reassert after rd_busy falls.
- A readout before the line is full returns 0 for unfilled taps.

Decomposition:
- Package tdl_pkg:
  - default DATA_W/TAPS constants;
  - typedef enum rd_state_t {RD_IDLE, RD_ACTIVE}.
- Sub-module tap_read_seq: the readout FSM and index counter. It takes rd_start and TAPS and produces rd_busy, rd_valid, rd_idx and rd_last.
- The top level keeps the tap array, fill counter and output mux.

Test Plan:
1. rst, then accept 1..17 with TAPS=17 and DATA_W=14:
   - fill_cnt steps 1..17;
   - full rises after the 17th accept;
   - tap k = 17-k.
2. Continue with 18, 19, 20:
   - fill_cnt stays 17;
   - tap0 = 20, tap16 = 4;
   - 0x3FFF passes through unchanged.
3. After step 1, pulse rd_start:
   - 17 rd_valid cycles, rd_data = 17, 16, ..., 1;
   - rd_last only at rd_idx 16;
   - in_ready = 0 throughout;
   - in_valid with 99 during the readout is not accepted; taps are unchanged.
4. Accept 0x1FFF with head_flag on a full line:
   - tap0 = 0x1FFF, taps 1..16 = 0, fill_cnt = 1, full = 0.
5. Accept 5 and pulse rd_start in the same cycle:
   - first rd_data = 5;
   - a second rd_start during the rd_last cycle produces no further rd_valid.
6. Assert clear at rd_idx 6, and separately assert rst mid-stream:
   - next cycle rd_valid = 0, all taps = 0, fill_cnt = 0, in_ready = 1.
